// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin grant of one requester's word, shifted out MSB first on one serial line.
// Latency: grant edge E0, frame bits on E1..E_WORD_SIZE, next grant no earlier than E_(WORD_SIZE+1+GAP_CYCLES).
// Backpressure: req is a level held by the requester until its ack pulse; req/enable are only looked at in IDLE.
module serial_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_SIZE  = 27,
  parameter int GAP_CYCLES = 0
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          enable,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [NUM_REQ*WORD_SIZE-1:0]                  word_in,
  output logic [NUM_REQ-1:0]                            ack,
  output logic                                          serialOut,
  output logic                                          validOut,
  output logic                                          busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]        gap_cnt, gap_cnt_nxt;
  logic [IW-1:0]        last, last_nxt;
  logic [IW-1:0]        grant_nxt;
  logic [IW-1:0]        winner;
  logic                 win_found;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 serial_nxt;
  logic                 valid_nxt;

  // Busy is the only unregistered output: it reflects the current state directly.
  assign busy = (state != IDLE);

  // Round-robin pick: first active request searching upward from the requester after the last winner.
  always_comb begin
    winner    = last;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[(int'(last) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        winner    = IW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  // State register plus all registered datapath/outputs; reset abandons any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      last      <= IW'(NUM_REQ - 1);
      grant_id  <= '0;
      ack       <= '0;
      serialOut <= 1'b0;
      validOut  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      last      <= last_nxt;
      grant_id  <= grant_nxt;
      ack       <= ack_nxt;
      serialOut <= serial_nxt;
      validOut  <= valid_nxt;
    end
  end

  // Next state: grant from IDLE, leave SHIFT after bit 0, hold GAP for GAP_CYCLES cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && (|req)) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (int'(gap_cnt) >= GAP_CYCLES - 1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values: capture the winner's word at grant, then shift one bit per cycle.
  always_comb begin
    ack_nxt     = '0;
    serial_nxt  = 1'b0;
    valid_nxt   = 1'b0;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    last_nxt    = last;
    grant_nxt   = grant_id;
    case (state)
      IDLE: begin
        if (enable && (|req)) begin
          ack_nxt[winner] = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) shift_nxt = word_in[i*WORD_SIZE +: WORD_SIZE];
          end
          bit_cnt_nxt = CW'(WORD_SIZE - 1);
          last_nxt    = winner;
          grant_nxt   = winner;
        end
      end
      SHIFT: begin
        serial_nxt  = shift_reg[bit_cnt];
        valid_nxt   = 1'b1;
        bit_cnt_nxt = (bit_cnt == '0) ? '0 : (bit_cnt - CW'(1));
        gap_cnt_nxt = '0;
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt + GW'(1);
      end
      default: begin
        gap_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: two instances (no gap, gap of 3) share stimulus.
// A time-since-grant model predicts every output each cycle; directed sections pin the model with literals.
module tb_serial_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 27;
  localparam int IW = 2;

  logic           clock   = 1'b0;
  logic           reset   = 1'b1;
  logic           enable  = 1'b0;
  logic [N-1:0]   req     = '0;
  logic [N*W-1:0] word_in = '0;

  logic [N-1:0]  ack0, ack3;
  logic          ser0, ser3, vld0, vld3, busy0, busy3;
  logic [IW-1:0] gid0, gid3;

  always #5 clock = ~clock;

  serial_tx_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .req(req), .word_in(word_in),
    .ack(ack0), .serialOut(ser0), .validOut(vld0), .busy(busy0), .grant_id(gid0)
  );

  serial_tx_arbiter #(.NUM_REQ(N), .WORD_SIZE(W), .GAP_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .req(req), .word_in(word_in),
    .ack(ack3), .serialOut(ser3), .validOut(vld3), .busy(busy3), .grant_id(gid3)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model: outputs derived from cycles elapsed since the grant ----------------
  int           gapc   [2] = '{0, 3};
  bit           m_act  [2];
  int           m_t    [2];
  int           m_last [2];
  logic [W-1:0] m_word [2];
  logic [N-1:0] e_ack  [2];
  logic         e_ser  [2];
  logic         e_vld  [2];
  logic         e_busy [2];
  int           e_gid  [2];

  task automatic model_reset(input int m);
    m_act[m]  = 1'b0;
    m_t[m]    = 0;
    m_last[m] = N - 1;
    m_word[m] = '0;
    e_ack[m]  = '0;
    e_ser[m]  = 1'b0;
    e_vld[m]  = 1'b0;
    e_busy[m] = 1'b0;
    e_gid[m]  = 0;
  endtask

  task automatic model_step(input int m);
    int w;
    e_ack[m] = '0;
    e_ser[m] = 1'b0;
    e_vld[m] = 1'b0;
    if (m_act[m] && (m_t[m] + 1 < W + 1 + gapc[m])) begin
      m_t[m]++;
      if (m_t[m] <= W) begin
        e_ser[m] = m_word[m][W - m_t[m]];
        e_vld[m] = 1'b1;
      end
    end else begin
      m_act[m] = 1'b0;
      if (enable && (req != '0)) begin
        w = m_last[m];
        for (int k = 1; k <= N; k++) begin
          if (req[(m_last[m] + k) % N]) begin
            w = (m_last[m] + k) % N;
            break;
          end
        end
        e_ack[m][w] = 1'b1;
        m_word[m]   = word_in[w*W +: W];
        m_t[m]      = 0;
        m_act[m]    = 1'b1;
        m_last[m]   = w;
        e_gid[m]    = w;
      end
    end
    e_busy[m] = m_act[m] && (m_t[m] < W + gapc[m]);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      cyc++;
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare and grant log ----------------
  int g0_cyc[$];
  int g0_id[$];
  int g3_cyc[$];
  int g3_id[$];

  always @(negedge clock) begin
    if (!reset) begin
      check("ack0",  ack0,  e_ack[0]);
      check("ser0",  ser0,  e_ser[0]);
      check("vld0",  vld0,  e_vld[0]);
      check("busy0", busy0, e_busy[0]);
      check("gid0",  gid0,  e_gid[0]);
      check("ack3",  ack3,  e_ack[1]);
      check("ser3",  ser3,  e_ser[1]);
      check("vld3",  vld3,  e_vld[1]);
      check("busy3", busy3, e_busy[1]);
      check("gid3",  gid3,  e_gid[1]);
      if (ack0 != '0) begin g0_cyc.push_back(cyc); g0_id.push_back(int'(gid0)); end
      if (ack3 != '0) begin g3_cyc.push_back(cyc); g3_id.push_back(int'(gid3)); end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ack0(input string name, input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit && ok == 0; i++) begin
      tick(1);
      if (ack0 != '0) ok = 1;
    end
    check(name, ok, 1);
  endtask

  function automatic logic [N*W-1:0] rand_words();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  logic [W-1:0] frame;
  logic [W-1:0] w0;
  int           nv;
  int           nack;

  initial begin
    // Reset state
    tick(3);
    check("rst_ser",  ser0,  0);
    check("rst_vld",  vld0,  0);
    check("rst_busy", busy0, 0);
    check("rst_gid",  gid0,  0);
    check("rst_ack",  ack0,  0);
    reset = 1'b0;
    tick(1);

    // Single request from requester 2
    word_in = rand_words();
    word_in[2*W +: W] = 27'h5A5A5A5;
    req    = 4'b0100;
    enable = 1'b1;
    wait_ack0("t1_ack_seen", 5);
    check("t1_ack", ack0, 4'b0100);
    check("t1_gid", gid0, 2);
    req   = '0;
    frame = '0;
    nv    = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (vld0) begin frame = {frame[W-2:0], ser0}; nv++; end
    end
    check("t1_frame", frame, 27'h5A5A5A5);
    check("t1_valid_cycles", nv, 27);

    // Round robin with all requesters held
    do_reset();
    g0_cyc.delete(); g0_id.delete();
    word_in = rand_words();
    req     = 4'b1111;
    for (int i = 0; i < 200 && g0_id.size() < 5; i++) tick(1);
    req = '0;
    tick(1);
    check("t2_grant_count", g0_id.size() >= 5, 1);
    if (g0_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("t2_order", g0_id[i], i % 4);
      for (int i = 1; i < 5; i++) check("t2_spacing", g0_cyc[i] - g0_cyc[i-1], 28);
    end

    // Gap spacing: requester 0 held
    do_reset();
    g0_cyc.delete(); g0_id.delete(); g3_cyc.delete(); g3_id.delete();
    req = 4'b0001;
    tick(120);
    req = '0;
    check("t3_gap_grant_count", g3_cyc.size() >= 3, 1);
    if (g3_cyc.size() >= 3) begin
      check("t3_gap_spacing_a", g3_cyc[1] - g3_cyc[0], 31);
      check("t3_gap_spacing_b", g3_cyc[2] - g3_cyc[1], 31);
    end
    if (g0_cyc.size() >= 2) check("t3_nogap_spacing", g0_cyc[1] - g0_cyc[0], 28);

    // Reset in the middle of a frame
    do_reset();
    word_in[2*W +: W] = '1;
    req = 4'b0100;
    wait_ack0("t4_ack_seen", 5);
    req = '0;
    tick(10);
    check("t4_ser_before", ser0, 1);
    check("t4_busy_before", busy0, 1);
    #2 reset = 1'b1;
    #1;
    check("t4_ser_rst",  ser0,  0);
    check("t4_vld_rst",  vld0,  0);
    check("t4_busy_rst", busy0, 0);
    check("t4_gid_rst",  gid0,  0);
    check("t4_busy3_rst", busy3, 0);
    tick(1);
    req = 4'b1010;
    tick(1);
    reset = 1'b0;
    wait_ack0("t4_ack_after", 5);
    check("t4_gid_after", gid0, 1);
    check("t4_ack_after_val", ack0, 4'b0010);
    req = '0;

    // Enable gating and word/enable stability during a frame
    do_reset();
    enable = 1'b0;
    req    = 4'b0001;
    nack   = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ack0 != '0) nack++;
    end
    check("t5_no_ack", nack, 0);
    w0 = W'($urandom);
    word_in[0 +: W] = w0;
    enable = 1'b1;
    tick(1);
    check("t5_ack_next_edge", ack0, 4'b0001);
    frame = '0;
    for (int i = 0; i < W; i++) begin
      enable = 1'($urandom);
      word_in[0 +: W] = W'($urandom);
      req = 4'($urandom);
      tick(1);
      frame = {frame[W-2:0], ser0};
    end
    check("t5_frame", frame, w0);
    enable = 1'b0;
    req    = '0;

    // Requester 3 arrives as requester 0's frame ends
    do_reset();
    enable = 1'b1;
    req    = 4'b0001;
    wait_ack0("t6_ack0_seen", 5);
    check("t6_first_gid", gid0, 0);
    tick(26);
    req = 4'b1001;
    wait_ack0("t6_ack3_seen", 5);
    check("t6_second_gid", gid0, 3);
    wait_ack0("t6_ack_back_seen", 40);
    check("t6_third_ack", ack0, 4'b0001);
    req = '0;

    // Randomised traffic with occasional resets
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) word_in = rand_words();
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(1);
    end
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
